frontend_packet_queue: RTL

//  Parametrised decoupling queue between pipeline stages of the frontend.

---
 rtl/frontend_packet_queue_if.sv | 22 ++
 rtl/frontend_packet_queue.sv | 93 +++++++++
 2 files changed

// File: rtl/frontend_packet_queue_if.sv
// Enqueue/dequeue handshake bundle for frontend_packet_queue.
// master = producer/consumer side, slave = the queue itself.
interface frontend_packet_queue_if #(
    parameter int unsigned WIDTH = 64
);
    logic             enq_valid;
    logic             enq_ready;
    logic [WIDTH-1:0] enq_data;
    logic             deq_valid;
    logic             deq_ready;
    logic [WIDTH-1:0] deq_data;

    modport master (
        output enq_valid, enq_data, deq_ready,
        input  enq_ready, deq_valid, deq_data
    );

    modport slave (
        input  enq_valid, enq_data, deq_ready,
        output enq_ready, deq_valid, deq_data
    );
endinterface

// File: rtl/frontend_packet_queue.sv
// In-order valid/ready decoupling queue between frontend pipeline stages,
// with flush, optional empty-queue bypass and an almost-full indication.
module frontend_packet_queue #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned BYPASS    = 0,
    parameter int unsigned AF_THRESH = DEPTH - 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    frontend_packet_queue_if.slave       pq,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    logic             empty;
    logic             full;
    logic             bypass_empty;
    logic             enq_rdy;
    logic             deq_vld;
    logic [WIDTH-1:0] head_data;
    logic             enq_fire;
    logic             deq_fire;
    logic             pass_through;
    logic             do_wr;
    logic             do_rd;

    always_comb begin
        empty        = (count == '0);
        full         = (count == FULL_CNT);
        bypass_empty = (BYPASS != 0) && empty;

        // enq_ready depends only on registered count, never on deq_ready
        enq_rdy = ~full & ~flush & ~rst;

        if (bypass_empty) begin
            deq_vld   = pq.enq_valid & ~flush & ~rst;
            head_data = pq.enq_data;
        end else begin
            deq_vld   = ~empty & ~flush & ~rst;
            head_data = mem[rd_ptr];
        end

        enq_fire     = pq.enq_valid & enq_rdy;
        deq_fire     = deq_vld & pq.deq_ready;
        // A bypassed packet consumed the same cycle never touches storage
        pass_through = bypass_empty & deq_fire;
        do_wr        = enq_fire & ~pass_through;
        do_rd        = deq_fire & ~bypass_empty;

        almost_full  = (count >= AF_CNT);
    end

    assign pq.enq_ready = enq_rdy;
    assign pq.deq_valid = deq_vld;
    assign pq.deq_data  = deq_vld ? head_data : '0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is intentionally left uncleared by rst/flush
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= pq.enq_data;
        end
    end
endmodule
